instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multicycle RISC-V instruction-fetch stage that feeds the main control FSM.
//  - On request from the controller: reads instruction memory at PC, waits out a fixed memory latency,
//    latches the word into the instruction register and advances PC by 4.
//  - Presents the raw instruction and its decoded fields (opcode/rd/rs1/rs2/funct3/funct7)
//    that the controller dispatches on.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  MEM_LATENCY  2              cycles mem_rd is held before mem_rdata is valid (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  fetch_req    in   1   controller requests next instruction (sampled in IDLE only)
//  pc_load      in   1   controller overwrites PC (branch/jump)
//  pc_in        in   32  new PC value when pc_load=1
//  mem_rd       out  1   instruction memory read strobe
//  mem_addr     out  32  instruction memory byte address
//  mem_rdata    in   32  instruction memory read data
//  pc           out  32  current PC register
//  ir           out  32  instruction register
//  instr_valid  out  1   one-cycle pulse: ir holds newly fetched word
//  busy         out  1   fetch in progress (state READ)
//  fetch_fault  out  1   one-cycle pulse: misaligned fetch (see CONFIGURATION)
//  opcode out 7 = ir[6:0]; rd out 5 = ir[11:7]; funct3 out 3 = ir[14:12];
//  rs1 out 5 = ir[19:15]; rs2 out 5 = ir[24:20]; funct7 out 7 = ir[31:25]
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, pc=RESET_PC, ir=0, cnt=0.
//    mem_rd, instr_valid, busy, fetch_fault = 0. In-flight read is discarded.
//  - FSM states: IDLE, READ, DONE. All outputs except the decode fields are registered or Moore.
//  - IDLE:
//    - pc_load=1 -> pc<=pc_in.
//    - fetch_req=1 -> READ, cnt<=MEM_LATENCY-1.
//    - Both asserted together: pc is loaded first, and the fetch uses the new pc.
//  - READ:
//    - mem_rd=1, busy=1, mem_addr={pc[31:2],2'b00}.
//    - cnt!=0 -> cnt<=cnt-1.
//    - cnt==0 -> ir<=mem_rdata, pc<=pc+4 (32-bit wrap, 0xFFFFFFFC+4=0), go to DONE.
//    - pc_load and fetch_req are ignored in READ.
//  - DONE:
//    - instr_valid=1 for exactly one cycle, then IDLE.
//    - pc_load honoured (overrides the incremented pc).
//    - fetch_req is ignored.
//  - Latency: fetch_req sampled at cycle 0 -> mem_rd high cycles 1..L -> instr_valid high cycle L+1.
//    A held fetch_req gives one instruction per L+2 cycles.
//  - ir and pc are stable outside the READ->DONE update edge; decode fields are combinational from ir.
//  - cnt width = $clog2(MEM_LATENCY+1).
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    - fetch_req in IDLE with pc[1:0]!=2'b00 -> no READ; goes to DONE with fetch_fault=1, instr_valid=0.
//    - ir and pc are unchanged; mem_rd never asserts.
//  FETCH_ALIGN_CHECK_EN undefined:
//    - fetch_fault tied 0; pc[1:0] ignored for addressing (forced 00); pc+4 keeps the low bits.
// TESTING (MEM_LATENCY=2, RESET_PC=0 unless stated)
//  1. rst pulse mid-run -> pc=0, ir=0, mem_rd=0, instr_valid=0, busy=0 immediately (before the next clk edge).
//  2. fetch_req 1 cycle, mem[0]=32'h00B50533
//     -> mem_rd cycles 1-2 at addr 0; cycle 3 instr_valid=1, ir=00B50533,
//        opcode=7'h33, rd=10, rs1=10, rs2=11, funct3=0, funct7=0; pc=4.
//  3. fetch_req held high -> mem_addr 0,4,8 on successive reads; instr_valid every 4 cycles.
//  4. pc_load=1, pc_in=32'h100 together with fetch_req in IDLE -> mem_addr=0x100; pc=0x104 after DONE.
//  5. rst asserted during first READ cycle -> IDLE at once; no instr_valid; ir=0.
//     Next fetch restarts from addr 0.
//  6. pc_load 32'h102 then fetch_req:
//     - with FETCH_ALIGN_CHECK_EN -> fetch_fault one cycle, mem_rd stays 0, pc=0x102;
//     - without it -> read at 0x100, pc=0x106.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction-fetch stage: reads instruction memory at pc, latches ir, advances pc.
// Optional misaligned-fetch detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_in,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_fault,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef FETCH_ALIGN_CHECK_EN
    // The alignment check must see the pc the fetch will actually use.
    logic [31:0] fetch_pc;
    assign fetch_pc = pc_load ? pc_in : pc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ir          <= 32'h0;
            cnt         <= '0;
            mem_rd      <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_load)
                        pc <= pc_in;
                    if (fetch_req) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        if (fetch_pc[1:0] != 2'b00) begin
                            state       <= DONE;
                            fetch_fault <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state  <= READ;
                            cnt    <= CNT_INIT;
                            mem_rd <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ir          <= mem_rdata;
                        pc          <= pc + 32'd4;
                        state       <= DONE;
                        mem_rd      <= 1'b0;
                        busy        <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                DONE: begin
                    instr_valid <= 1'b0;
                    fetch_fault <= 1'b0;
                    if (pc_load)
                        pc <= pc_in;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr = {pc[31:2], 2'b00};

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (MEM_LATENCY=2, RESET_PC=0) with a word-addressed memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        instr_valid;
    logic        busy;
    logic        fetch_fault;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;

    logic [31:0] mem [0:127];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];

    instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load), .pc_in(pc_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .pc(pc), .ir(ir),
        .instr_valid(instr_valid), .busy(busy), .fetch_fault(fetch_fault),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++)
            mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h00B5_0533;

        rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_in = 32'h0;
        step(); step();
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fetch_fault, 0);
        rst = 1'b0;
        step();

        // Single fetch with decode of add a0,a0,a1
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("t2_c1_mem_rd", mem_rd, 1);
        check("t2_c1_busy", busy, 1);
        check("t2_c1_addr", mem_addr, 32'h0);
        check("t2_c1_valid", instr_valid, 0);
        step();
        check("t2_c2_mem_rd", mem_rd, 1);
        check("t2_c2_pc", pc, 32'h0);
        step();
        check("t2_c3_valid", instr_valid, 1);
        check("t2_c3_mem_rd", mem_rd, 0);
        check("t2_ir", ir, 32'h00B5_0533);
        check("t2_opcode", opcode, 32'h33);
        check("t2_rd", rd, 10);
        check("t2_rs1", rs1, 10);
        check("t2_rs2", rs2, 11);
        check("t2_funct3", funct3, 0);
        check("t2_funct7", funct7, 0);
        check("t2_pc", pc, 32'h4);
        step();
        check("t2_c4_valid", instr_valid, 0);

        // Asynchronous reset during the first READ cycle
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("t5_in_read", mem_rd, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_pc", pc, 32'h0);
        check("t5_async_ir", ir, 32'h0);
        check("t5_async_mem_rd", mem_rd, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_valid", instr_valid, 0);
        step();
        rst = 1'b0;
        step();
        check("t5_no_valid", instr_valid, 0);

        // Held fetch_req: back-to-back fetches from addr 0, one per 4 cycles
        fetch_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t3_addr%0d", k), mem_addr, 32'(4 * k));
            check($sformatf("t3_rd%0d", k), mem_rd, 1);
            step();
            step();
            check($sformatf("t3_valid%0d", k), instr_valid, 1);
            check($sformatf("t3_ir%0d", k), ir, mem[k]);
            if (k == 2) fetch_req = 1'b0;
            step();
            check($sformatf("t3_gap%0d", k), instr_valid, 0);
        end
        check("t3_pc", pc, 32'hC);

        // pc_load together with fetch_req; pc_load ignored while in READ
        pc_load = 1'b1; pc_in = 32'h100; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0; pc_in = 32'h300;
        check("t4_addr", mem_addr, 32'h100);
        step();
        check("t4_pc_hold", pc, 32'h100);
        step();
        pc_load = 1'b0;
        check("t4_valid", instr_valid, 1);
        check("t4_ir", ir, mem[64]);
        check("t4_pc", pc, 32'h104);
        step();

        // Misaligned pc
        pc_load = 1'b1; pc_in = 32'h102;
        step();
        pc_load = 1'b0;
        check("t6_pc_loaded", pc, 32'h102);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_fault", fetch_fault, 1);
        check("t6_mem_rd", mem_rd, 0);
        check("t6_valid", instr_valid, 0);
        step();
        check("t6_fault_clr", fetch_fault, 0);
        check("t6_pc", pc, 32'h102);
`else
        check("t6_addr", mem_addr, 32'h100);
        check("t6_fault", fetch_fault, 0);
        step();
        step();
        check("t6_valid", instr_valid, 1);
        check("t6_pc", pc, 32'h106);
        check("t6_ir", ir, mem[64]);
        step();
`endif

        // pc wrap at top of address space, then pc_load honoured in DONE
        pc_load = 1'b1; pc_in = 32'hFFFF_FFFC;
        step();
        pc_load = 1'b0; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        step();
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_ir", ir, mem[127]);
        pc_load = 1'b1; pc_in = 32'h200;
        step();
        pc_load = 1'b0;
        check("done_load_pc", pc, 32'h200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
